// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 fetch path.
package ysyx_220053_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [63:0] PC_RESET = 64'h8000_0000;
    localparam int unsigned INST_W   = 32;

endpackage

// File: rtl/ysyx_220053_imem_array.sv
// Instruction storage: one synchronous write port, one combinational read port.
module ysyx_220053_imem_array
    import ysyx_220053_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INST_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INST_W-1:0]        rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_220053_imem_resp.sv
// Instruction-memory responder: valid/ready fetch request in, word + error out
// after a fixed programmable latency, with a side load port for preloading.
module ysyx_220053_imem_resp
    import ysyx_220053_pkg::*;
#(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [63:0] BASE    = PC_RESET,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [INST_W-1:0] resp_inst,
    output logic              resp_err,
    input  logic              ld_en,
    input  logic [63:0]       ld_addr,
    input  logic [INST_W-1:0] ld_data,
    output logic [31:0]       fetch_cnt
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [63:0]       req_off;
    logic [63:0]       ld_off;
    logic              req_err;
    logic              ld_ok;
    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     ld_idx;
    logic [INST_W-1:0] rd_word;

    always_comb begin
        req_off = req_addr - BASE;
        req_err = (req_addr[1:0] != 2'b00) || (req_addr < BASE) || (req_off >= SPAN);
        req_idx = AW'(req_off >> 2);
        ld_off  = ld_addr - BASE;
        ld_ok   = (ld_addr[1:0] == 2'b00) && (ld_addr >= BASE) && (ld_off < SPAN);
        ld_idx  = AW'(ld_off >> 2);
    end

    assign req_ready = (state == IDLE);

    // Read is combinational and the write lands on the edge, so a load on the
    // accept edge leaves the captured word at its old value.
    ysyx_220053_imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (ld_en && ld_ok),
        .waddr (ld_idx),
        .wdata (ld_data),
        .raddr (req_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_inst  <= '0;
            resp_err   <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        resp_inst <= req_err ? '0 : rd_word;
                        resp_err  <= req_err;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        fetch_cnt  <= fetch_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_220053_imem_resp.md
Name: ysyx_220053_imem_resp

Overview:
Instruction-memory responder that serves the fetch requests issued by the IFU PC register.
- Accepts one 64-bit fetch address at a time over a valid/ready request channel.
- Returns a 32-bit instruction word and an error flag after a programmable latency, over a valid/ready response channel.
- Has a side load port so the simulation or boot harness can preload the program image.
- Sits between the fetch stage and instruction storage; replaces the combinational pmem read path.

Parameters:
- DEPTH, 4096, number of 32-bit words in the array (power of 2).
- BASE, 64'h80000000, byte address of word 0 (matches PC reset value).
- LATENCY, 2, cycles from request-accept edge to resp_valid high; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert handled upstream.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  64  fetch byte address (PC).
- resp_valid  out  1  response present.
- resp_ready  in  1  fetch stage accepts the response.
- resp_inst  out  32  instruction word; 32'h0 when resp_err = 1.
- resp_err  out  1  misaligned or out-of-range fetch.
- ld_en  in  1  load-port write strobe.
- ld_addr  in  64  load byte address (same mapping as req_addr).
- ld_data  in  32  load word.
- fetch_cnt  out  32  count of completed response handshakes.

Behaviour:
- Reset (rst = 0, immediate):
  - state = IDLE, resp_valid = 0, resp_inst = 0, resp_err = 0, fetch_cnt = 0, latency counter = 0.
  - Array contents are not reset.
  - Reset mid-WAIT or mid-RESP discards the in-flight fetch silently.
- States: IDLE, WAIT, RESP. req_ready = (state == IDLE), combinational from state only.
- IDLE:
  - A request is accepted on an edge where req_valid & req_ready.
  - At that edge: address decode and array read happen; the word and error flag are captured into internal response registers.
  - Next state is WAIT with cnt = LATENCY-1 if LATENCY > 1, otherwise RESP.
- WAIT: cnt decrements each cycle; when cnt == 1, next state is RESP.
- Latency rule: resp_valid is high exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid = 1; resp_inst and resp_err are held stable while resp_valid & !resp_ready.
  - On resp_valid & resp_ready: fetch_cnt += 1 (wraps at 2^32 → 0), next state is IDLE, resp_valid drops next cycle.
  - Throughput: one fetch per LATENCY+1 cycles minimum.
- Decode, using 64-bit arithmetic: off = req_addr - BASE.
  - in_range = (req_addr >= BASE) && (off < 4*DEPTH).
  - misaligned = req_addr[1:0] != 0.
  - err = misaligned | !in_range.
  - idx = off[log2(DEPTH)+1:2].
- Error fetches follow the same timing; resp_inst = 0, resp_err = 1; fetch_cnt still increments.
- Load port:
  - On an edge with ld_en and an aligned, in-range ld_addr, the array word is written.
  - Bad ld_addr is ignored with no error.
  - Writes are legal in every state.
- Read-before-write: a load to the same index on the accept edge does not affect the captured word; the fetch returns old data.
- Loads after the accept edge never alter an in-flight response.
- req_addr and req_valid are ignored outside IDLE; requesters must hold the request until req_ready.

Decomposition:
- Shared package ysyx_220053_pkg:
  - state enum {IDLE, WAIT, RESP}, 2 bits.
  - constant PC_RESET = 64'h80000000, used as the default BASE.
  - constant INST_W = 32.
- Sub-module ysyx_220053_imem_array:
  - parameter DEPTH.
  - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr → rdata).
  - Decode, FSM, counters and response registers stay in the top module.

Test Plan:
- Preload [0x80000000] = 0x00000413, LATENCY = 2; request 0x80000000 with resp_ready tied 1.
  → req_ready low the cycle after accept; resp_valid high exactly 2 cycles after accept; resp_inst = 0x00000413, resp_err = 0; fetch_cnt = 1.
- Request 0x80000002, then 0x7FFFFFFC, then 0x80004000 (DEPTH = 4096).
  → each gives resp_err = 1, resp_inst = 0 with normal latency; fetch_cnt = 3.
- Preload [0x80000010] = 0xAAAA0000. Assert ld_en writing 0x55550000 to the same address on the accept edge of a fetch of 0x80000010.
  → response 0xAAAA0000; the next fetch of the same address returns 0x55550000.
- Hold resp_ready = 0 for 5 cycles after resp_valid rises, while toggling req_valid with new addresses.
  → resp_inst and resp_err stable; req_ready stays 0; no extra acceptance; one handshake once resp_ready = 1.
- Pull rst low in the middle of WAIT.
  → resp_valid = 0, fetch_cnt = 0, req_ready = 1 immediately after release; preloaded array contents intact on the next fetch.
- Run with LATENCY = 1 and LATENCY = 15, issuing 3 back-to-back fetches with resp_ready = 1.
  → resp_valid spacing equals LATENCY+1 cycles between accepts.
